note_sched: RTL

Round-robin scheduler that shares the single key-to-frequency scaler (8-bit piano key 1..88 in, 32-bit frequency in centi-Hz out) among NV independent synthesis voices of the player. Each voice posts a note change. The block queues one pending request per voice, drives the shared scaler one voice at a time, and latches the result into that voice's frequency register for the oscillators downstream.

---
 rtl/note_sched_pkg.sv | 23 ++
 rtl/note_sched_rr_arb.sv | 42 ++++
 rtl/note_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/note_sched_pkg.sv
// note_sched_pkg
// Shared widths, key range limits and FSM state type for the voice scheduler.
// The key-range check lives here so the capture path and any future users
// agree on what counts as a playable piano key.
package note_sched_pkg;

    localparam int NOTE_W   = 8;
    localparam int FREQ_W   = 32;
    localparam int NOTE_MIN = 1;
    localparam int NOTE_MAX = 88;

    typedef enum logic {
        IDLE,
        LOOK
    } state_t;

    // A key is playable only inside 1..88; 0 is a rest and anything above
    // 88 is an illegal request.
    function automatic logic is_legal_key(input logic [NOTE_W-1:0] key);
        return (key >= NOTE_W'(NOTE_MIN)) && (key <= NOTE_W'(NOTE_MAX));
    endfunction

endpackage

// File: rtl/note_sched_rr_arb.sv
// rr_arb
// Combinational round-robin arbiter. The search starts at the voice just
// after the last granted one and wraps, so every requester is reached
// within NV grants.
// Ports:
//   req_i   NV-wide request vector
//   last_i  index of the most recently granted requester
//   gnt_o   one-hot grant (all zero when nothing requests)
//   idx_o   index of the granted requester (0 when nothing requests)
module rr_arb #(
    parameter int NV = 4,
    parameter int IW = $clog2(NV)
) (
    input  logic [NV-1:0] req_i,
    input  logic [IW-1:0] last_i,
    output logic [NV-1:0] gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] cand;
    logic          found;

    // Walk the requesters in rotated priority order, taking the first hit.
    // Offsets run 1..NV so the last granted voice is considered last.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NV; i++) begin
            if (!found) begin
                cand = IW'((int'(last_i) + i) % NV);
                if (req_i[cand]) begin
                    found        = 1'b1;
                    idx_o        = cand;
                    gnt_o[cand]  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/note_sched.sv
// note_sched
// Shares one key-to-frequency scaler among NV synthesis voices. Each voice
// posts a key; legal keys are queued (one pending request per voice) and
// looked up one at a time in round-robin order, rests and illegal keys
// bypass the scaler and zero the voice immediately.
// Optional feature: define NOTE_SCHED_TRANSPOSE_EN to add transpose_i, a
// signed semitone offset applied (and clamped to 1..88) at grant time.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   note_i         per-voice key (0 rest, 1..88 legal, 89..255 illegal)
//   note_vld_i     per-voice load strobe
//   transpose_i    signed semitone offset (only with NOTE_SCHED_TRANSPOSE_EN)
//   scl_note_o     registered key presented to the shared scaler
//   scl_freq_i     combinational scaler result for scl_note_o
//   freq_o         per-voice frequency in centi-Hz
//   freq_vld_o     one-cycle pulse when freq_o of that voice updates
//   gate_o         voice currently holds a playable note
//   err_o          sticky flag, set by any illegal key
//   busy_o         a request is pending or a lookup is in flight
module note_sched
    import note_sched_pkg::*;
#(
    parameter int NV = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NV-1:0][NOTE_W-1:0]     note_i,
    input  logic [NV-1:0]                 note_vld_i,
`ifdef NOTE_SCHED_TRANSPOSE_EN
    input  logic signed [NOTE_W-1:0]      transpose_i,
`endif
    output logic [NOTE_W-1:0]             scl_note_o,
    input  logic [FREQ_W-1:0]             scl_freq_i,
    output logic [NV-1:0][FREQ_W-1:0]     freq_o,
    output logic [NV-1:0]                 freq_vld_o,
    output logic [NV-1:0]                 gate_o,
    output logic                          err_o,
    output logic                          busy_o
);

    localparam int IW = $clog2(NV);

    state_t                    state_q, state_d;
    logic [NV-1:0]             pend_q;
    logic [NV-1:0][NOTE_W-1:0] note_q;
    logic [IW-1:0]             gidx_q;
    logic [IW-1:0]             last_q;
    logic [NV-1:0]             arb_gnt;
    logic [IW-1:0]             arb_idx;
    logic                      load;
    logic                      done;
    logic [NOTE_W-1:0]         scl_next;

    rr_arb #(
        .NV (NV),
        .IW (IW)
    ) u_arb (
        .req_i  (pend_q),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

`ifdef NOTE_SCHED_TRANSPOSE_EN
    logic signed [9:0] tsum;

    // Transposition is done in 10-bit signed so that key 88 + 127 or
    // key 1 - 128 cannot wrap before clamping back into the piano range.
    always_comb begin
        tsum     = $signed({2'b00, note_q[arb_idx]}) + 10'(transpose_i);
        scl_next = tsum[NOTE_W-1:0];
        if (tsum < 10'(NOTE_MIN)) begin
            scl_next = NOTE_W'(NOTE_MIN);
        end else if (tsum > 10'(NOTE_MAX)) begin
            scl_next = NOTE_W'(NOTE_MAX);
        end
    end
`else
    // Without transposition the queued key goes to the scaler unchanged.
    always_comb begin
        scl_next = note_q[arb_idx];
    end
`endif

    // State register for the two-phase lookup: IDLE picks a voice and
    // presents its key, LOOK captures the scaler answer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A fresh strobe on the voice being looked up means the
    // in-flight answer is already stale, so the completion is suppressed and
    // the voice stays pending to be served again with its new key.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    load    = 1'b1;
                    state_d = LOOK;
                end
            end
            LOOK: begin
                state_d = IDLE;
                done    = !note_vld_i[gidx_q];
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant bookkeeping: remember which voice owns the scaler and which voice
    // was served last so the arbiter rotates. Starting last_q at NV-1 makes
    // voice 0 the first winner after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_note_o <= '0;
            gidx_q     <= '0;
            last_q     <= IW'(NV - 1);
        end else begin
            if (load) begin
                scl_note_o <= scl_next;
                gidx_q     <= arb_idx;
            end
            if (done) begin
                last_q <= gidx_q;
            end
        end
    end

    // Per-voice state. Lookup completion is applied first; a strobe in the
    // same cycle on another voice is independent, and a strobe on the
    // granted voice has already cancelled the completion above. Rests and
    // illegal keys zero the voice directly and drop any pending request so
    // the voice is never granted with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            note_q     <= '0;
            freq_o     <= '0;
            freq_vld_o <= '0;
            gate_o     <= '0;
            err_o      <= 1'b0;
        end else begin
            freq_vld_o <= '0;
            if (done) begin
                freq_o[gidx_q]     <= scl_freq_i;
                gate_o[gidx_q]     <= 1'b1;
                freq_vld_o[gidx_q] <= 1'b1;
                pend_q[gidx_q]     <= 1'b0;
            end
            for (int v = 0; v < NV; v++) begin
                if (note_vld_i[v]) begin
                    note_q[v] <= note_i[v];
                    if (is_legal_key(note_i[v])) begin
                        pend_q[v] <= 1'b1;
                    end else begin
                        pend_q[v]     <= 1'b0;
                        freq_o[v]     <= '0;
                        gate_o[v]     <= 1'b0;
                        freq_vld_o[v] <= 1'b1;
                        if (note_i[v] != '0) begin
                            err_o <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Busy is derived purely from registered state.
    assign busy_o = (|pend_q) || (state_q == LOOK);

endmodule
